// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Walks the select of a 16:1 bit multiplexer through the enabled channels in
// ascending order. Each channel is held for dwell+1 cycles so that the mux
// output can settle, and the mux output is captured on the last of those
// cycles. The samples are packed into a 16-bit capture word, and a one-cycle
// done pulse marks the end of the scan.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          synchronous active-low reset
//   i_start          one-cycle scan request, honoured only while idle
//   i_enable_mask    channel i is scanned when bit i is set (latched at start)
//   i_dwell          extra settle cycles per channel (latched at start)
//   i_mux_out        single-bit output of the 16:1 mux
//   o_sel            select driven to the mux
//   o_sample_strobe  high in the cycle whose closing edge captures i_mux_out
//   o_capture        bit i = sampled value of channel i, 0 when disabled
//   o_busy           high while settling/sampling channels
//   o_done           one-cycle pulse when the scan completes
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int N_CH    = 16,
    parameter int SEL_W   = 4,   // must equal $clog2(N_CH)
    parameter int DWELL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [N_CH-1:0]    i_enable_mask,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_mux_out,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_sample_strobe,
    output logic [N_CH-1:0]    o_capture,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic [N_CH-1:0]    r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [N_CH-1:0]    r_capture;

    state_t             w_state_next;
    logic [SEL_W-1:0]   w_sel_next;
    logic [DWELL_W-1:0] w_cnt_next;
    logic [N_CH-1:0]    w_mask_next;
    logic [DWELL_W-1:0] w_dwell_next;
    logic [N_CH-1:0]    w_capture_next;

    logic [SEL_W-1:0]   w_first_sel;
    logic               w_next_found;
    logic [SEL_W-1:0]   w_next_sel;

    // Lowest set bit of the incoming mask: the first channel of a new scan.
    // Scanning from the top down leaves the lowest hit as the final value.
    always_comb begin
        w_first_sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_enable_mask[i]) begin
                w_first_sel = SEL_W'(i);
            end
        end
    end

    // Next enabled channel strictly above the current select, from the
    // latched mask so that mid-scan mask changes cannot alter the order.
    always_comb begin
        w_next_found = 1'b0;
        w_next_sel   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_found = 1'b1;
                w_next_sel   = SEL_W'(i);
            end
        end
    end

    // NOTE: every signal gets its hold value before the case statement, so no
    // path through the block leaves a signal unassigned and no latch appears.
    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_cnt_next     = r_cnt;
        w_mask_next    = r_mask;
        w_dwell_next   = r_dwell;
        w_capture_next = r_capture;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_capture_next = '0;
                    if (|i_enable_mask) begin
                        w_mask_next  = i_enable_mask;
                        w_dwell_next = i_dwell;
                        w_sel_next   = w_first_sel;
                        w_cnt_next   = i_dwell;
                        w_state_next = S_SETTLE;
                    end else begin
                        // Nothing to scan: report completion straight away.
                        w_state_next = S_DONE;
                    end
                end
            end

            S_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - DWELL_W'(1);
                end else begin
                    w_capture_next[r_sel] = i_mux_out;
                    if (w_next_found) begin
                        w_sel_next = w_next_sel;
                        w_cnt_next = r_dwell;
                    end else begin
                        // Select stays on the last channel through DONE.
                        w_state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the values from before this edge, independent of order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_dwell   <= '0;
            r_capture <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_cnt     <= w_cnt_next;
            r_mask    <= w_mask_next;
            r_dwell   <= w_dwell_next;
            r_capture <= w_capture_next;
        end
    end

    // All status outputs decode registered state only.
    assign o_sel           = r_sel;
    assign o_capture       = r_capture;
    assign o_busy          = (r_state == S_SETTLE);
    assign o_done          = (r_state == S_DONE);
    assign o_sample_strobe = (r_state == S_SETTLE) && (r_cnt == '0);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Feeds the sequencer from a modelled 16:1 mux (a pattern word indexed by the
// select). Expected per-cycle outputs come from a reference model that lists
// the enabled channels in ascending order, holds each for dwell+1 cycles,
// strobes on the last of them, and then emits one done cycle.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] enable_mask;
    logic [3:0]  dwell;
    logic        mux_out;
    logic [3:0]  sel;
    logic        sample_strobe;
    logic [15:0] capture;
    logic        busy;
    logic        done;

    logic [15:0] mux_pattern;

    int n_total = 0;
    int n_bad   = 0;

    // One expected output cycle: capture, sel, busy, strobe, done.
    typedef struct packed {
        logic [15:0] cap;
        logic [3:0]  sel;
        logic        busy;
        logic        strobe;
        logic        done;
    } obs_t;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  dwell;
        logic [15:0] pattern;
        int          disturb_at;
        bit          start_in_done;
        logic [15:0] exp_cap;
        int          exp_busy;
    } vec_t;

    obs_t        trace_q[$];
    logic [3:0]  m_sel;
    vec_t        vecs[7];

    mux_scan_sequencer #(
        .N_CH    (16),
        .SEL_W   (4),
        .DWELL_W (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_enable_mask   (enable_mask),
        .i_dwell         (dwell),
        .i_mux_out       (mux_out),
        .o_sel           (sel),
        .o_sample_strobe (sample_strobe),
        .o_capture       (capture),
        .o_busy          (busy),
        .o_done          (done)
    );

    // The 16:1 mux being scanned.
    assign mux_out = mux_pattern[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.cap    = capture;
        o.sel    = sel;
        o.busy   = busy;
        o.strobe = sample_strobe;
        o.done   = done;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs for every cycle from the one after start through done.
    task automatic build_trace(input logic [15:0] mask, input logic [3:0] dw,
                               input logic [15:0] pattern);
        obs_t        e;
        logic [15:0] cap;
        trace_q.delete();
        cap = '0;
        for (int ch = 0; ch < 16; ch++) begin
            if (mask[ch]) begin
                for (int d = 0; d <= int'(dw); d++) begin
                    e.cap    = cap;
                    e.sel    = 4'(ch);
                    e.busy   = 1'b1;
                    e.strobe = (d == int'(dw));
                    e.done   = 1'b0;
                    trace_q.push_back(e);
                end
                cap[ch] = pattern[ch];
                m_sel   = 4'(ch);
            end
        end
        e.cap    = cap;
        e.sel    = m_sel;
        e.busy   = 1'b0;
        e.strobe = 1'b0;
        e.done   = 1'b1;
        trace_q.push_back(e);
    endtask

    // Called just after a falling edge. disturb_at: trace index at which a
    // stray start plus a new mask/dwell are driven. abort_at: trace index at
    // which reset is asserted instead of finishing the scan.
    task automatic run_scan(input logic [15:0] mask, input logic [3:0] dw,
                            input logic [15:0] pattern, input int disturb_at,
                            input bit start_in_done, input int abort_at,
                            output int busy_cycles, output logic [15:0] final_cap);
        obs_t exp_idle;
        busy_cycles = 0;
        final_cap   = '0;
        mux_pattern = pattern;
        enable_mask = mask;
        dwell       = dw;
        start       = 1'b1;
        build_trace(mask, dw, pattern);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < trace_q.size(); i++) begin
            check($sformatf("trace[%0d] m=%h d=%0d", i, mask, dw), 32'(observe()), 32'(trace_q[i]));
            if (busy) busy_cycles++;
            if (done) final_cap = capture;
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("reset mid-scan", 32'(observe()), 32'h0);
                rst_n = 1'b1;
                m_sel = '0;
                @(negedge clk);
                check("idle after mid-scan reset", 32'(observe()), 32'h0);
                return;
            end
            if (i == disturb_at) begin
                start       = 1'b1;
                enable_mask = 16'hFFFF;
                dwell       = ~dw;
            end
            if (start_in_done && (i == trace_q.size() - 1)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        // Two idle cycles: capture and sel hold, no queued start takes effect.
        exp_idle      = trace_q[trace_q.size() - 1];
        exp_idle.done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("idle after scan m=%h +%0d", mask, k), 32'(observe()), 32'(exp_idle));
            @(negedge clk);
        end
    endtask

    initial begin
        int          bcnt;
        logic [15:0] fcap;
        logic [15:0] rmask;
        logic [3:0]  rdw;

        vecs[0] = '{16'hFFFF, 4'd0,  16'hA5C3, -1, 1'b0, 16'hA5C3, 16};
        vecs[1] = '{16'h8101, 4'd3,  16'hFFFF, -1, 1'b0, 16'h8101, 12};
        vecs[2] = '{16'h0000, 4'd5,  16'hFFFF, -1, 1'b0, 16'h0000, 0};
        vecs[3] = '{16'h00F0, 4'd1,  16'h0A50,  3, 1'b1, 16'h0050, 8};
        vecs[4] = '{16'h0001, 4'd15, 16'h0001, -1, 1'b0, 16'h0001, 16};
        vecs[5] = '{16'h8000, 4'd0,  16'h8000, -1, 1'b1, 16'h8000, 1};
        vecs[6] = '{16'hFFFF, 4'd0,  16'h5A3C,  7, 1'b0, 16'h5A3C, 16};

        rst_n       = 1'b0;
        start       = 1'b0;
        enable_mask = '0;
        dwell       = '0;
        mux_pattern = '0;
        m_sel       = '0;

        // Reset, then a quiet idle period.
        repeat (2) @(negedge clk);
        check("reset state", 32'(observe()), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle %0d", i), 32'(observe()), 32'h0);
        end

        // Directed table.
        foreach (vecs[v]) begin
            run_scan(vecs[v].mask, vecs[v].dwell, vecs[v].pattern, vecs[v].disturb_at,
                     vecs[v].start_in_done, -1, bcnt, fcap);
            check($sformatf("vec%0d capture", v), 32'(fcap), 32'(vecs[v].exp_cap));
            check($sformatf("vec%0d busy cycles", v), 32'(bcnt), 32'(vecs[v].exp_busy));
        end

        // Reset while channel 5 is first selected, then a normal scan.
        run_scan(16'hFFFF, 4'd2, 16'hFFFF, -1, 1'b0, 15, bcnt, fcap);
        run_scan(16'h0F0F, 4'd1, 16'h3333, -1, 1'b0, -1, bcnt, fcap);
        check("post-reset scan capture", 32'(fcap), 32'h0303);
        check("post-reset scan busy", 32'(bcnt), 32'd16);

        // Randomized scans against the reference model.
        for (int r = 0; r < 25; r++) begin
            rmask = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rmask = '0;
                1, 2: rmask = rmask & 16'($urandom) & 16'($urandom);
                default: ;
            endcase
            rdw = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            run_scan(rmask, rdw, 16'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1,
                     1'($urandom_range(0, 1)), -1, bcnt, fcap);
            check($sformatf("rand%0d busy cycles", r), 32'(bcnt),
                  32'($countones(rmask) * (int'(rdw) + 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream/downstream companion to the team's 16:1 bit multiplexer.
- Drives the mux's 4-bit select through enabled channels, waits a programmable settle time on each, then samples the single-bit mux output.
- Packs the samples into a 16-bit capture word and signals completion.
- Sits between the control/register logic (start, mask, dwell) and the 16:1 mux (sel out, mux_out in).

Parameters:
- N_CH, 16, number of mux channels; fixed at 16 for this revision.
- SEL_W, 4, select width; must equal log2(N_CH).
- DWELL_W, 4, width of the per-channel settle count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- enable_mask  input  16  channel i is scanned when bit i = 1; latched at start.
- dwell  input  DWELL_W  extra settle cycles per channel; latched at start.
- mux_out  input  1  output of the 16:1 mux.
- sel  output  SEL_W  select driven to the mux.
- sample_strobe  output  1  high in the cycle whose closing edge captures mux_out.
- capture  output  16  bit i = sampled value of channel i; 0 for disabled channels.
- busy  output  1  high in SETTLE.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset values (rst_n low at an edge): state IDLE, sel 0, capture 0, sample_strobe 0, busy 0, done 0, internal counter 0, latched mask/dwell 0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Edge with start = 1 and enable_mask != 0:
    - latch mask and dwell; clear capture to 0;
    - set sel to the index of the lowest set mask bit;
    - set counter to dwell; go to SETTLE.
  - Edge with start = 1 and enable_mask = 0: clear capture and go directly to DONE.
  - Otherwise sel and capture hold their values.
- SETTLE:
  - busy = 1.
  - counter != 0: decrement; sel holds.
  - counter = 0: sample_strobe = 1 in that cycle, and at the closing edge capture[sel] <= mux_out. Then:
    - if a higher latched mask bit is set, move sel to the next higher set bit, reload counter with the latched dwell, and stay in SETTLE;
    - otherwise go to DONE, with sel holding the last channel.
  - Each enabled channel therefore occupies exactly dwell+1 cycles. A scan of k channels spends k*(dwell+1) cycles in SETTLE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0; go to IDLE at the next edge.
  - capture is stable from entry to DONE until the next accepted start.
- start outside IDLE (SETTLE or DONE) is ignored; it is neither queued nor does it restart the scan.
- Changes to enable_mask or dwell during a scan have no effect until the next accepted start.
- Channel ordering is always ascending index. Disabled channels are never driven on sel and never sampled.
- Reset asserted mid-scan: at the next edge, all outputs return to reset values and no done pulse is issued.
- dwell = 0: one cycle per channel; sample_strobe is held high continuously across consecutive channels.
- sample_strobe, busy and done are decoded from registered state; no combinational path runs from inputs to outputs.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> sel=0, capture=0x0000, busy=0, done=0; start=0 for 10 cycles -> no change.
- Full scan: mask=0xFFFF, dwell=0, mux In pattern=0xA5C3 fed back through the 16:1 mux -> sel steps 0..15 on consecutive cycles, busy high 16 cycles, done pulses once, capture=0xA5C3.
- Sparse scan with dwell: mask=0x8101, dwell=3, mux input all ones -> sel visits 0, 8, 15 for 4 cycles each, 12 busy cycles, capture=0x8101.
- Empty mask: start with mask=0x0000 -> no busy cycles, done at the cycle after start, capture=0x0000.
- Ignored start and late mask change: during a mask=0x00F0 scan, pulse start and change mask to 0xFFFF -> scan still covers only channels 4..7, exactly one done pulse.
- Reset mid-scan: mask=0xFFFF, dwell=2, assert rst_n low at the sel=5 cycle -> next edge sel=0, capture=0, busy=0, no done pulse; a subsequent scan completes normally.
